// File: rtl/gpio_pin_irq.sv
// Pin-change interrupt stage: synchronises GPIO pins, latches per-bit edge flags
// and raises a level interrupt for masked pending flags. Sits on the 8-bit I/O bus.
module gpio_pin_irq #(
    parameter logic [7:0] IRQ_ADDRESS = 8'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    input  logic [7:0] pins,
    output logic       irq
);

    localparam logic [7:0] OffMask  = 8'd0;
    localparam logic [7:0] OffRise  = 8'd1;
    localparam logic [7:0] OffFall  = 8'd2;
    localparam logic [7:0] OffFlags = 8'd3;
    localparam logic [7:0] OffPins  = 8'd4;

    logic [7:0] mask_q, rise_q, fall_q, flags_q;
    logic [7:0] sync1_q, sync2_q, prev_q;
    logic [7:0] dout_q;
    logic       irq_q;
    logic [1:0] warmup_q;

    logic [7:0] offset;
    logic       hit;
    logic [7:0] edges;
    logic [7:0] clr;
    logic [7:0] flags_d;
    logic [7:0] rdata;

    assign offset = address - IRQ_ADDRESS;
    assign hit    = (offset <= OffPins);

    always_comb begin
        edges   = 8'h00;
        clr     = 8'h00;
        rdata   = 8'h00;
        // Edges are ignored until the synchroniser holds only post-reset samples.
        if (warmup_q == 2'd3) begin
            edges = (rise_q & sync2_q & ~prev_q) | (fall_q & ~sync2_q & prev_q);
        end
        if (w_en && (offset == OffFlags)) begin
            clr = din;
        end
        flags_d = (flags_q & ~clr) | edges;
        case (offset)
            OffMask:  rdata = mask_q;
            OffRise:  rdata = rise_q;
            OffFall:  rdata = fall_q;
            OffFlags: rdata = flags_q;
            OffPins:  rdata = sync2_q;
            default:  rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= 8'h00;
            rise_q   <= 8'h00;
            fall_q   <= 8'h00;
            flags_q  <= 8'h00;
            sync1_q  <= 8'h00;
            sync2_q  <= 8'h00;
            prev_q   <= 8'h00;
            dout_q   <= 8'h00;
            irq_q    <= 1'b0;
            warmup_q <= 2'd0;
        end else begin
            sync1_q <= pins;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (warmup_q != 2'd3) begin
                warmup_q <= warmup_q + 2'd1;
            end
            flags_q <= flags_d;
            irq_q   <= |(flags_q & mask_q);
            if (w_en) begin
                case (offset)
                    OffMask: mask_q <= din;
                    OffRise: rise_q <= din;
                    OffFall: fall_q <= din;
                    default: ;
                endcase
            end
            if (r_en && hit) begin
                dout_q <= rdata;
            end
        end
    end

    assign dout = dout_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_gpio_pin_irq.sv
// Bench for gpio_pin_irq: directed scenarios with literal expectations, then random bus
// and pin traffic compared every cycle against a sample-history reference model.
module tb_gpio_pin_irq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic [7:0] address;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;
    logic [7:0] pins;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_pin_irq #(.IRQ_ADDRESS(8'h04)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .address (address),
        .w_en    (w_en),
        .r_en    (r_en),
        .dout    (dout),
        .pins    (pins),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, exp);
        end
    endtask

    // Reference model: pin samples taken at each post-reset edge, newest first.
    // ps[1] is what the bus sees as PINS; an edge compares ps[1] with ps[2] once
    // three post-reset samples exist.
    logic [7:0] ps[$];
    logic [7:0] m_mask, m_rise, m_fall, m_flags, m_dout;
    logic       m_irq;
    logic [7:0] m_off;

    assign m_off = address - 8'h04;

    function automatic logic [7:0] pin_at(input int k);
        return (ps.size() > k) ? ps[k] : 8'h00;
    endfunction

    function automatic logic [7:0] edge_f();
        logic [7:0] cur, old;
        if (ps.size() < 3) return 8'h00;
        cur = ps[1];
        old = ps[2];
        return (m_rise & cur & ~old) | (m_fall & ~cur & old);
    endfunction

    function automatic logic [7:0] rd_f();
        case (m_off)
            8'd0:    return m_mask;
            8'd1:    return m_rise;
            8'd2:    return m_fall;
            8'd3:    return m_flags;
            default: return pin_at(1);
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mask  <= 8'h00;
            m_rise  <= 8'h00;
            m_fall  <= 8'h00;
            m_flags <= 8'h00;
            m_dout  <= 8'h00;
            m_irq   <= 1'b0;
            ps.delete();
        end else begin
            if (r_en && m_off < 8'd5) m_dout <= rd_f();
            m_irq   <= |(m_flags & m_mask);
            m_flags <= (m_flags & ~((w_en && m_off == 8'd3) ? din : 8'h00)) | edge_f();
            if (w_en && m_off == 8'd0) m_mask <= din;
            if (w_en && m_off == 8'd1) m_rise <= din;
            if (w_en && m_off == 8'd2) m_fall <= din;
            ps.push_front(pins);
            if (ps.size() > 4) void'(ps.pop_back());
        end
    end

    always @(negedge clk) begin
        chk("model_dout", dout, m_dout);
        chk("model_irq", {7'b0, irq}, {7'b0, m_irq});
    end

    // Called at a falling edge; returns at the next falling edge with strobes dropped.
    task automatic bus(input logic we, input logic re, input logic [7:0] a, input logic [7:0] d);
        w_en    = we;
        r_en    = re;
        address = a;
        din     = d;
        @(negedge clk);
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        pins    = 8'hFF;
        din     = 8'h00;
        address = 8'h00;
        w_en    = 1'b0;
        r_en    = 1'b0;

        // Pins high through reset must not raise flags.
        repeat (3) @(negedge clk);
        chk("reset_dout", dout, 8'h00);
        chk("reset_irq", {7'b0, irq}, 8'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        bus(1'b0, 1'b1, 8'h08, 8'h00);
        chk("warm_pins", dout, 8'hFF);
        bus(1'b0, 1'b1, 8'h07, 8'h00);
        chk("warm_flags", dout, 8'h00);
        chk("warm_irq", {7'b0, irq}, 8'h00);

        // Rising edge on bit 0: irq three edges after the pin change.
        pins = 8'h00;
        repeat (5) @(negedge clk);
        bus(1'b1, 1'b0, 8'h04, 8'h01);
        bus(1'b1, 1'b0, 8'h05, 8'h01);
        pins = 8'h01;
        repeat (3) @(negedge clk);
        chk("rise_irq_k2", {7'b0, irq}, 8'h00);
        @(negedge clk);
        chk("rise_irq_k3", {7'b0, irq}, 8'h01);
        bus(1'b0, 1'b1, 8'h07, 8'h00);
        chk("rise_flags", dout, 8'h01);

        // W1C clears; irq drops one edge later.
        bus(1'b1, 1'b0, 8'h07, 8'h01);
        chk("w1c_irq_hold", {7'b0, irq}, 8'h01);
        @(negedge clk);
        chk("w1c_irq_low", {7'b0, irq}, 8'h00);
        bus(1'b1, 1'b0, 8'h07, 8'h00);
        bus(1'b0, 1'b1, 8'h07, 8'h00);
        chk("w1c_flags", dout, 8'h00);

        // Both-edge detect with irq masked, then unmask a pending flag.
        bus(1'b1, 1'b0, 8'h05, 8'hF0);
        bus(1'b1, 1'b0, 8'h06, 8'hF0);
        bus(1'b1, 1'b0, 8'h04, 8'h00);
        pins = 8'hF1;
        repeat (4) @(negedge clk);
        bus(1'b0, 1'b1, 8'h07, 8'h00);
        chk("any_flags", dout, 8'hF0);
        chk("any_irq_masked", {7'b0, irq}, 8'h00);
        bus(1'b1, 1'b0, 8'h04, 8'h80);
        chk("unmask_irq_k", {7'b0, irq}, 8'h00);
        @(negedge clk);
        chk("unmask_irq_k1", {7'b0, irq}, 8'h01);
        bus(1'b1, 1'b0, 8'h07, 8'hF0);
        repeat (2) @(negedge clk);

        // Clear of bit 2 lands on the same edge that sets it: set wins.
        bus(1'b1, 1'b0, 8'h05, 8'h04);
        pins = 8'hF5;
        repeat (2) @(negedge clk);
        bus(1'b1, 1'b0, 8'h07, 8'h04);
        bus(1'b0, 1'b1, 8'h07, 8'h00);
        chk("set_wins", dout, 8'h04);

        // Register readback, unmapped read, async reset while pending.
        bus(1'b1, 1'b0, 8'h04, 8'h04);
        bus(1'b0, 1'b1, 8'h04, 8'h00);
        chk("rd_mask", dout, 8'h04);
        bus(1'b0, 1'b1, 8'h05, 8'h00);
        chk("rd_rise", dout, 8'h04);
        bus(1'b0, 1'b1, 8'h06, 8'h00);
        chk("rd_fall", dout, 8'hF0);
        bus(1'b0, 1'b1, 8'h07, 8'h00);
        chk("rd_flags", dout, 8'h04);
        bus(1'b0, 1'b1, 8'h08, 8'h00);
        chk("rd_pins", dout, 8'hF5);
        bus(1'b0, 1'b1, 8'h0B, 8'h00);
        chk("rd_unmapped", dout, 8'hF5);
        chk("pend_irq", {7'b0, irq}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("async_dout", dout, 8'h00);
        chk("async_irq", {7'b0, irq}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        bus(1'b0, 1'b1, 8'h07, 8'h00);
        chk("async_flags", dout, 8'h00);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int op;
            int b;
            if ($urandom_range(0, 2) == 0) begin
                b = $urandom_range(0, 7);
                pins[b] = ~pins[b];
            end
            op      = $urandom_range(0, 3);
            w_en    = (op == 1) || (op == 3);
            r_en    = (op == 2) || (op == 3);
            din     = 8'($urandom);
            address = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                  : 8'(8'h04 + $urandom_range(0, 5));
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end
        w_en = 1'b0;
        r_en = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
